// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction: PC-indexed saturating-counter table for fetch,
// EX-side condition resolve, mispredict redirect and a multi-cycle flush FSM.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_predict_unit #(
  parameter int PC_WIDTH     = 64,
  parameter int BHT_ENTRIES  = 16,
  parameter int CNT_WIDTH    = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] if_pc,
  output logic                if_pred_taken,
  input  logic                ex_valid,
  input  logic                ex_branch,
  input  logic [3:0]          ex_funct,
  input  logic                ex_zero,
  input  logic                ex_is_greater,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic [PC_WIDTH-1:0] ex_target,
  input  logic                ex_pred_taken,
  output logic                actual_taken,
  output logic                redirect,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic                flush,
  output logic                dbg_flush_state
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam int FLUSH_LOAD = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
  localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [CNT_WIDTH-1:0] WEAK_NT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

  typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] bht_q [BHT_ENTRIES];
  logic [CNT_WIDTH-1:0] bht_d [BHT_ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cond;
  logic             resolve;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign if_pred_taken   = bht_q[if_idx][CNT_WIDTH-1];
  assign dbg_flush_state = (state_q == S_FLUSH);

  always_comb begin
    cond = 1'b0;
    case (ex_funct[2:0])
      3'b000:  cond = ex_zero;
      3'b001:  cond = ~ex_zero;
      3'b101:  cond = ex_is_greater;
      3'b100:  cond = ~ex_is_greater;
      default: cond = 1'b0;
    endcase
  end

  // EX inputs are a one-cycle offer qualified by ex_valid; there is no backpressure,
  // and an offer arriving while flushing (or in reset) is dropped.
  assign resolve      = ex_valid & ex_branch & (state_q == S_IDLE) & ~reset;
  assign actual_taken = resolve & cond;
  assign redirect     = resolve & (actual_taken != ex_pred_taken);
  assign redirect_pc  = actual_taken ? ex_target : ex_pc + PC_WIDTH'(4);

  always_comb begin
    bht_d = bht_q;
    if (resolve) begin
      if (actual_taken) begin
        if (bht_q[ex_idx] != '1) bht_d[ex_idx] = bht_q[ex_idx] + CNT_WIDTH'(1);
      end else begin
        if (bht_q[ex_idx] != '0) bht_d[ex_idx] = bht_q[ex_idx] - CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    flush   = 1'b0;
    case (state_q)
      S_IDLE: begin
        flush = redirect;
        if (redirect && MULTI_FLUSH) begin
          state_d = S_FLUSH;
          fcnt_d  = FCNT_W'(FLUSH_LOAD);
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (fcnt_q == '0) state_d = S_IDLE;
        else              fcnt_d  = fcnt_q - FCNT_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WEAK_NT;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= bht_d[i];
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (resolve && stat_branches_q != 32'hFFFF_FFFF)
      stat_branches_d = stat_branches_q + 32'd1;
    if (redirect && stat_mispredicts_q != 32'hFFFF_FFFF)
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
